// File: rtl/async_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers.
// The read-side twin reuses the pointer type and the full/empty compare.
package async_fifo_pkg;

    localparam int FIFO_ADDR_W = 2;
    localparam int PTR_W       = FIFO_ADDR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Inverting the two MSBs of a Gray pointer yields the pointer exactly DEPTH ahead.
    localparam ptr_t FULL_MASK = ptr_t'(2'b11) << (PTR_W - 2);

    // True when write Gray pointer w is a full FIFO ahead of read Gray pointer r.
    function automatic logic full_cmp(ptr_t w, ptr_t r);
        return (w == (r ^ FULL_MASK));
    endfunction

endpackage

// File: rtl/async_fifo_wptr_ctrl_chk.sv
// Checker for the write pointer controller: the read pointer must never
// run ahead of the write pointer, which would show up as an occupancy above DEPTH.
module async_fifo_wptr_ctrl_chk #(
    parameter int PTR_W = 3,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    input logic [PTR_W-1:0] level_next
);

    localparam logic [PTR_W-1:0] DEPTH_V = PTR_W'(DEPTH);

    level_le_depth_a : assert property (@(posedge clk) disable iff (reset) level_next <= DEPTH_V);

endmodule

// File: rtl/bin2gray.sv
// Library binary-to-Gray converter (purely combinational).
module bin2gray #(
    parameter int BIT_WIDTH = 3
) (
    input  logic [BIT_WIDTH-1:0] bin_i,
    output logic [BIT_WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray2bin.sv
// Library Gray-to-binary converter (purely combinational).
module gray2bin #(
    parameter int BIT_WIDTH = 3
) (
    input  logic [BIT_WIDTH-1:0] gray_i,
    output logic [BIT_WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at and above its position.
    always_comb begin
        bin_o = '0;
        bin_o[BIT_WIDTH-1] = gray_i[BIT_WIDTH-1];
        for (int i = BIT_WIDTH - 2; i >= 0; i--) begin
            bin_o[i] = bin_o[i+1] ^ gray_i[i];
        end
    end

endmodule

// File: rtl/async_fifo_wptr_ctrl.sv
// Write-side pointer controller of the dual-clock FIFO.
// Owns the binary and Gray write pointers, gates pushes, and derives
// full / almost_full / level against the synchronised read Gray pointer.
module async_fifo_wptr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_W    = FIFO_ADDR_W,
    parameter int AF_THRESH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rptr_gray_sync,
    output logic              wr_accept,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              ovf_err
);

    localparam int                   W_PTR    = ADDR_W + 1;
    localparam int                   DEPTH    = 2 ** ADDR_W;
    localparam logic [W_PTR-1:0]     AF_LEVEL = W_PTR'(DEPTH - AF_THRESH);
    // Same MSB-pair inversion as full_cmp, sized for this instance's pointer width.
    localparam logic [W_PTR-1:0]     F_MASK   = W_PTR'(2'b11) << (W_PTR - 2);

    logic [W_PTR-1:0] wbin_q, wbin_d;
    logic [W_PTR-1:0] wptr_gray_q;
    logic [W_PTR-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;
    logic [W_PTR-1:0] gray_next_s;
    logic [W_PTR-1:0] rbin_sync_s;

    assign wr_accept = wr_en & ~full_q;

    bin2gray #(.BIT_WIDTH(W_PTR)) u_bin2gray (
        .bin_i  (wbin_d),
        .gray_o (gray_next_s)
    );

    gray2bin #(.BIT_WIDTH(W_PTR)) u_gray2bin (
        .gray_i (rptr_gray_sync),
        .bin_o  (rbin_sync_s)
    );

    // Next-state: advance on accepted push, fold in the read pointer for full/level.
    always_comb begin
        wbin_d  = wbin_q;
        if (wr_accept) begin
            wbin_d = wbin_q + W_PTR'(1);
        end else begin
            wbin_d = wbin_q;
        end
        level_d = wbin_d - rbin_sync_s;
        full_d  = (gray_next_s == (rptr_gray_sync ^ F_MASK));
        af_d    = (level_d >= AF_LEVEL);
        ovf_d   = ovf_q | (wr_en & full_q);
    end

    // State registers; reset takes priority over any push in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbin_q      <= '0;
            wptr_gray_q <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            af_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wptr_gray_q <= gray_next_s;
            level_q     <= level_d;
            full_q      <= full_d;
            af_q        <= af_d;
            ovf_q       <= ovf_d;
        end
    end

    assign waddr       = wbin_q[ADDR_W-1:0];
    assign wptr_gray   = wptr_gray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign level       = level_q;
    assign ovf_err     = ovf_q;

    async_fifo_wptr_ctrl_chk #(.PTR_W(W_PTR), .DEPTH(DEPTH)) u_chk (
        .clk        (clk),
        .reset      (reset),
        .level_next (level_d)
    );

endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// Scoreboard bench for async_fifo_wptr_ctrl (ADDR_W=2, AF_THRESH=1).
module tb_async_fifo_wptr_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] rptr_gray_sync = 3'b000;
    logic       wr_accept;
    logic [1:0] waddr;
    logic [2:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [2:0] level;
    logic       ovf_err;

    async_fifo_wptr_ctrl #(.ADDR_W(2), .AF_THRESH(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .rptr_gray_sync (rptr_gray_sync),
        .wr_accept      (wr_accept),
        .waddr          (waddr),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .level          (level),
        .ovf_err        (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] gray;
        logic [1:0] waddr;
        logic       full;
        logic       af;
        logic [2:0] lvl;
        logic       ovf;
    } exp_t;

    logic acc_q[$];
    exp_t reg_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: occupancy counter view of the FIFO.
    int m_wbin = 0;
    int m_lvl  = 0;
    int m_full = 0;
    int m_af   = 0;
    int m_ovf  = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic we, input logic [2:0] rg, input logic rst);
        exp_t e;
        int   acc;
        int   rb;
        @(negedge clk);
        wr_en          = we;
        rptr_gray_sync = rg;
        reset          = rst;
        acc = (we && !m_full) ? 1 : 0;
        acc_q.push_back(acc[0]);
        if (rst) begin
            m_wbin = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            if (we && m_full) m_ovf = 1;
            if (acc != 0) m_wbin = (m_wbin + 1) % 8;
            rb     = rg ^ (rg >> 1) ^ (rg >> 2);
            m_lvl  = (m_wbin - rb + 8) % 8;
            m_full = (m_lvl == 4) ? 1 : 0;
            m_af   = (m_lvl >= 3) ? 1 : 0;
        end
        e.gray  = 3'(m_wbin ^ (m_wbin >> 1));
        e.waddr = 2'(m_wbin % 4);
        e.full  = m_full[0];
        e.af    = m_af[0];
        e.lvl   = 3'(m_lvl);
        e.ovf   = m_ovf[0];
        reg_q.push_back(e);
    endtask

    // Monitor: combinational strobe before the edge, registered outputs after it.
    initial begin
        logic a;
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (acc_q.size() > 0) begin
                a = acc_q.pop_front();
                chk("wr_accept", {7'd0, wr_accept}, {7'd0, a});
            end
            @(posedge clk); #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                chk("wptr_gray",   {5'd0, wptr_gray},   {5'd0, e.gray});
                chk("waddr",       {6'd0, waddr},       {6'd0, e.waddr});
                chk("full",        {7'd0, full},        {7'd0, e.full});
                chk("almost_full", {7'd0, almost_full}, {7'd0, e.af});
                chk("level",       {5'd0, level},       {5'd0, e.lvl});
                chk("ovf_err",     {7'd0, ovf_err},     {7'd0, e.ovf});
                chk("level_max",   {7'd0, (level <= 3'd4)}, 8'd1);
            end
        end
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int         rb;
        logic [2:0] rg;
        // Reset then idle.
        repeat (3) step(1'b0, 3'b000, 1'b1);
        repeat (3) step(1'b0, 3'b000, 1'b0);
        // Fill: four pushes.
        repeat (4) step(1'b1, 3'b000, 1'b0);
        // Overflow attempts, then release.
        repeat (2) step(1'b1, 3'b000, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        // Read pointer advance frees a slot, one push refills.
        step(1'b0, 3'b001, 1'b0);
        step(1'b1, 3'b001, 1'b0);
        // Read advance alone, then push together with a read advance.
        step(1'b0, 3'b011, 1'b0);
        step(1'b1, 3'b010, 1'b0);
        // Wrap: alternate push and read advance from a clean reset.
        step(1'b0, 3'b000, 1'b1);
        rb = 0;
        rg = 3'b000;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, rg, 1'b0);
            rb = (rb + 1) % 8;
            rg = 3'(rb ^ (rb >> 1));
            step(1'b0, rg, 1'b0);
        end
        // Mid-burst reset with a push pending.
        repeat (3) step(1'b1, rg, 1'b0);
        step(1'b1, 3'b000, 1'b1);
        step(1'b0, 3'b000, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        // Drain the scoreboard.
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 8'(acc_q.size() + reg_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
